lcd_receiver: RTL and testbench

LCD_RECEIVER -- requirements
Module: lcd_receiver

---
 rtl/lcd_receiver.sv | 180 ++++++++++++++++++
 tb/tb_lcd_receiver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_receiver.sv
// HD44780-style 4-bit bus receiver: tracks the 3,3,3,2 init handshake, reassembles nibble pairs into bytes.
// Optional E-timing monitor is built when LCD_RECEIVER_TIMING_CHECK_EN is defined.
module lcd_receiver #(
    parameter int T_SETUP_NS      = 40,
    parameter int T_PW_NS         = 230,
    parameter int T_NIBBLE_GAP_NS = 1000,
    parameter int T_BYTE_GAP_NS   = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_clk_ns,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_nibble,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       rs_out,
    output logic       data_valid,
    output logic       init_done,
    output logic       timing_err,
    output logic       proto_err
);
    typedef enum logic [2:0] {S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_HIGH, S_LOW} state_t;

    state_t     state_q, state_d;
    logic       e_q, rs_q, rw_seen_q, armed_q, hi_rs_q;
    logic       rw_seen_d, armed_d, hi_rs_d;
    logic [3:0] nib_q, hi_q, hi_d;
    logic [7:0] data_out_q, data_out_d;
    logic       rs_out_q, rs_out_d, data_valid_q, data_valid_d;
    logic       init_done_q, init_done_d, proto_err_q, proto_err_d;
    logic       rise, fall, acc_fall;

    always_comb begin
        rise      = lcd_e & ~e_q;
        fall      = ~lcd_e & e_q;
        // A read anywhere inside the pulse poisons the whole strobe.
        acc_fall  = fall & armed_q & ~rw_seen_q;
        rw_seen_d = rise ? lcd_rw : (lcd_e ? (rw_seen_q | lcd_rw) : rw_seen_q);
        armed_d   = armed_q | rise;

        state_d      = state_q;
        hi_d         = hi_q;
        hi_rs_d      = hi_rs_q;
        data_out_d   = data_out_q;
        rs_out_d     = rs_out_q;
        data_valid_d = 1'b0;
        init_done_d  = init_done_q;
        proto_err_d  = proto_err_q & ~clr_err;

        if (fall & armed_q & rw_seen_q)
            proto_err_d = 1'b1;

        if (acc_fall) begin
            case (state_q)
                S_INIT0: state_d = (nib_q == 4'h3) ? S_INIT1 : S_INIT0;
                S_INIT1: state_d = (nib_q == 4'h3) ? S_INIT2 : S_INIT0;
                S_INIT2: state_d = (nib_q == 4'h3) ? S_INIT3 : S_INIT0;
                S_INIT3: begin
                    if (nib_q == 4'h2) begin
                        state_d     = S_HIGH;
                        init_done_d = 1'b1;
                    end else if (nib_q == 4'h3) begin
                        state_d = S_INIT3;
                    end else begin
                        state_d = S_INIT0;
                    end
                end
                S_HIGH: begin
                    hi_d    = nib_q;
                    hi_rs_d = rs_q;
                    state_d = S_LOW;
                end
                S_LOW: begin
                    data_out_d   = {hi_q, nib_q};
                    rs_out_d     = hi_rs_q;
                    data_valid_d = 1'b1;
                    state_d      = S_HIGH;
                    if (rs_q != hi_rs_q)
                        proto_err_d = 1'b1;
                end
                default: state_d = S_INIT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            nib_q        <= 4'h0;
            rw_seen_q    <= 1'b0;
            armed_q      <= 1'b0;
            hi_q         <= 4'h0;
            hi_rs_q      <= 1'b0;
            data_out_q   <= 8'h00;
            rs_out_q     <= 1'b0;
            data_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= lcd_e;
            rs_q         <= lcd_rs;
            nib_q        <= lcd_nibble;
            rw_seen_q    <= rw_seen_d;
            armed_q      <= armed_d;
            hi_q         <= hi_d;
            hi_rs_q      <= hi_rs_d;
            data_out_q   <= data_out_d;
            rs_out_q     <= rs_out_d;
            data_valid_q <= data_valid_d;
            init_done_q  <= init_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

`ifdef LCD_RECEIVER_TIMING_CHECK_EN
    localparam logic [23:0] SETUP_LIM = 24'(T_SETUP_NS);
    localparam logic [23:0] PW_LIM    = 24'(T_PW_NS);
    localparam logic [23:0] NGAP_LIM  = 24'(T_NIBBLE_GAP_NS);
    localparam logic [23:0] BGAP_LIM  = 24'(T_BYTE_GAP_NS);

    logic [23:0] setup_cnt_q, setup_cnt_d, pulse_cnt_q, pulse_cnt_d, gap_cnt_q, gap_cnt_d;
    logic        fall_seen_q, fall_seen_d, timing_err_q, timing_err_d, timing_new;

    function automatic logic [23:0] sat_add(input logic [23:0] cnt, input logic [7:0] inc);
        logic [24:0] sum;
        sum = {1'b0, cnt} + {17'd0, inc};
        return sum[24] ? 24'hFFFFFF : sum[23:0];
    endfunction

    always_comb begin
        setup_cnt_d = ((lcd_nibble != nib_q) || (lcd_rs != rs_q)) ? 24'd0
                                                                  : sat_add(setup_cnt_q, period_clk_ns);
        pulse_cnt_d = rise ? 24'd0 : sat_add(pulse_cnt_q, period_clk_ns);
        gap_cnt_d   = acc_fall ? 24'd0 : sat_add(gap_cnt_q, period_clk_ns);
        fall_seen_d = fall_seen_q | acc_fall;

        // Gap limit depends on whether the next strobe opens a byte or completes one.
        timing_new = (rise & (setup_cnt_q < SETUP_LIM))
                   | (fall & armed_q & (pulse_cnt_q < PW_LIM))
                   | (rise & fall_seen_q & init_done_q &
                      (((state_q == S_LOW)  && (gap_cnt_q < NGAP_LIM)) ||
                       ((state_q == S_HIGH) && (gap_cnt_q < BGAP_LIM))));
        timing_err_d = (timing_err_q & ~clr_err) | timing_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            setup_cnt_q  <= 24'd0;
            pulse_cnt_q  <= 24'd0;
            gap_cnt_q    <= 24'd0;
            fall_seen_q  <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            setup_cnt_q  <= setup_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            fall_seen_q  <= fall_seen_d;
            timing_err_q <= timing_err_d;
        end
    end

    assign timing_err = timing_err_q;
`else
    logic unused_timing_cfg;
    assign unused_timing_cfg = ^{period_clk_ns, 32'(T_SETUP_NS), 32'(T_PW_NS),
                                 32'(T_NIBBLE_GAP_NS), 32'(T_BYTE_GAP_NS)};
    assign timing_err = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign rs_out     = rs_out_q;
    assign data_valid = data_valid_q;
    assign init_done  = init_done_q;
    assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver: bytes go through a scoreboard queue, flags are checked directly.
module tb_lcd_receiver;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] period_clk_ns;
    logic       lcd_e, lcd_rs, lcd_rw, clr_err;
    logic [3:0] lcd_nibble;
    logic [7:0] data_out;
    logic       rs_out, data_valid, init_done, timing_err, proto_err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic       dv_prev = 1'b0;

`ifdef LCD_RECEIVER_TIMING_CHECK_EN
    localparam logic TCHK = 1'b1;
`else
    localparam logic TCHK = 1'b0;
`endif

    lcd_receiver dut (
        .clk(clk), .rst(rst), .period_clk_ns(period_clk_ns),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_nibble(lcd_nibble),
        .clr_err(clr_err), .data_out(data_out), .rs_out(rs_out), .data_valid(data_valid),
        .init_done(init_done), .timing_err(timing_err), .proto_err(proto_err)
    );

    always #10 clk = ~clk;

    // Monitor: every data_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte actual=%0h rs=%0b required=none", data_out, rs_out);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rs_out, data_out} !== e) begin
                    errors++;
                    $display("FAIL byte actual=%0h required=%0h", {rs_out, data_out}, e);
                end
            end
            checks++;
            if (dv_prev) begin
                errors++;
                $display("FAIL dv_width actual=2+ cycles required=1");
            end
        end
        dv_prev <= data_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: data setup, E high for hi cycles, then gap cycles idle.
    task automatic send_nib(input logic [3:0] n, input logic rs, input logic rw,
                            input int hi, input int gap, input bit clr_at_fall);
        lcd_nibble = n;
        lcd_rs     = rs;
        lcd_rw     = rw;
        repeat (4) @(negedge clk);
        lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        if (clr_at_fall) clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs, input int hi_pw, input int ngap, input int bgap);
        exp_q.push_back({rs, b});
        send_nib(b[7:4], rs, 1'b0, hi_pw, ngap, 1'b0);
        send_nib(b[3:0], rs, 1'b0, 15, bgap, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        period_clk_ns = 8'd20;
        lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_nibble = 4'h0; clr_err = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_rs_out", 32'(rs_out), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_timing_err", 32'(timing_err), 0);
        chk("rst_proto_err", 32'(proto_err), 0);

        // Legal init sequence
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        chk("init_done_before_2", 32'(init_done), 0);
        send_nib(4'h2, 1'b0, 1'b0, 15, 2000, 1'b0);
        chk("init_done", 32'(init_done), 1);
        chk("init_timing_err", 32'(timing_err), 0);
        chk("init_proto_err", 32'(proto_err), 0);

        // Legal byte 0x41, RS=1
        send_byte(8'h41, 1'b1, 15, 50, 2000);
        chk("byte41_timing_err", 32'(timing_err), 0);
        chk("byte41_proto_err", 32'(proto_err), 0);
        chk("byte41_hold_data", 32'(data_out), 32'h41);
        chk("byte41_hold_rs", 32'(rs_out), 1);

        // Short E pulse (5 clk = 100 ns) on the high nibble
        send_byte(8'h5A, 1'b0, 5, 50, 2000);
        chk("short_pw_timing_err", 32'(timing_err), 32'(TCHK));
        pulse_clr();
        chk("short_pw_clr", 32'(timing_err), 0);

        // Second byte only ~10 us after the first
        send_byte(8'h12, 1'b0, 15, 50, 500);
        send_byte(8'h34, 1'b0, 15, 50, 2000);
        chk("byte_gap_timing_err", 32'(timing_err), 32'(TCHK));
        pulse_clr();
        chk("byte_gap_clr", 32'(timing_err), 0);

        // Nibble gap ~260 ns
        send_byte(8'h7E, 1'b0, 15, 10, 2000);
        chk("nib_gap_timing_err", 32'(timing_err), 32'(TCHK));
        pulse_clr();

        // RS differs between halves: byte still emitted with the high-nibble RS
        exp_q.push_back({1'b0, 8'h63});
        send_nib(4'h6, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b1, 1'b0, 15, 2000, 1'b0);
        chk("rs_mismatch_proto_err", 32'(proto_err), 1);
        chk("rs_mismatch_timing_err", 32'(timing_err), 0);
        pulse_clr();
        chk("rs_mismatch_clr", 32'(proto_err), 0);

        // Read strobe is discarded; clr_err on the same cycle loses to the new error
        send_nib(4'h9, 1'b0, 1'b1, 15, 2000, 1'b1);
        chk("rw_proto_err", 32'(proto_err), 1);
        pulse_clr();
        send_byte(8'h25, 1'b0, 15, 50, 2000);
        chk("after_rw_hold_data", 32'(data_out), 32'h25);
        chk("after_rw_proto_err", 32'(proto_err), 0);

        // Bad init sequence 3,5,3,3,3,2
        do_reset();
        chk("rst2_data_out", 32'(data_out), 32'h00);
        chk("rst2_init_done", 32'(init_done), 0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h5, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        chk("bad_init_not_done", 32'(init_done), 0);
        send_nib(4'h2, 1'b0, 1'b0, 15, 2000, 1'b0);
        chk("bad_init_done", 32'(init_done), 1);
        chk("bad_init_proto_err", 32'(proto_err), 0);

        // Reset between high and low nibble
        send_nib(4'h4, 1'b0, 1'b0, 15, 50, 1'b0);
        do_reset();
        chk("midbyte_init_done", 32'(init_done), 0);
        chk("midbyte_valid", 32'(data_valid), 0);
        send_nib(4'h1, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        send_nib(4'h3, 1'b0, 1'b0, 15, 50, 1'b0);
        chk("midbyte_reinit_pending", 32'(init_done), 0);
        send_nib(4'h2, 1'b0, 1'b0, 15, 50, 1'b0);
        chk("midbyte_reinit_done", 32'(init_done), 1);

        repeat (5) @(negedge clk);
        chk("bytes_outstanding", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
